instr_fetch_unit: RTL and testbench

Instruction fetch and issue stage feeding the opcode decoder. The block holds the PC and issues sequential requests to a fixed-latency instruction memory. Returned words are buffered in a 2-entry queue and presented to decode over a valid/ready handshake, with opcode and PC attached. A redirect input is driven by the resolved `beq`; it flushes in-flight and buffered instructions and restarts fetch at the target.

---
 rtl/isa_pkg.sv | 24 ++
 rtl/ifu_queue.sv | 85 ++++++++
 rtl/instr_fetch_unit.sv | 114 +++++++++++
 tb/tb_instr_fetch_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode type and constants, legality check, default
// instruction width and fetch FSM states. Used by fetch and the control decoder.
package isa_pkg;

  localparam int INSTR_W_DEF = 16;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_RTYPE = 4'b0000;
  localparam opcode_t OP_LW    = 4'b0001;
  localparam opcode_t OP_SW    = 4'b0010;
  localparam opcode_t OP_BEQ   = 4'b0011;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } ifu_state_t;

  // Any opcode outside the four defined ones is reserved.
  function automatic logic is_legal_op(input opcode_t op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/ifu_queue.sv
// Two-entry in-order instruction queue. Slot 0 is always the head, so the
// head outputs come straight from registers. Push and pop may coincide;
// flush empties the queue (stored words become don't-care).
module ifu_queue #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic [ADDR_W-1:0]  push_pc,
  output logic [1:0]         count,
  output logic [INSTR_W-1:0] head_instr,
  output logic [ADDR_W-1:0]  head_pc
);

  localparam int DEPTH = 2;

  logic [1:0] count_reg;
  logic [1:0] count_next;
  logic [1:0] wr_idx;

  // After a pop everything shifts down one slot, so the tail lands one lower.
  assign wr_idx = count_reg - {1'b0, pop};

  // Occupancy bookkeeping; flush wins over a simultaneous pop.
  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else begin
      count_next = count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      localparam logic [1:0] SLOT = 2'(gi);
      logic [INSTR_W-1:0] instr_reg;
      logic [ADDR_W-1:0]  pc_reg;
      logic [INSTR_W-1:0] shift_instr;
      logic [ADDR_W-1:0]  shift_pc;

      if (gi < DEPTH - 1) begin : g_shift
        assign shift_instr = g_slot[gi+1].instr_reg;
        assign shift_pc    = g_slot[gi+1].pc_reg;
      end else begin : g_last
        assign shift_instr = instr_reg;
        assign shift_pc    = pc_reg;
      end

      // Slot update: a push aimed here wins, otherwise shift down on pop.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          instr_reg <= '0;
          pc_reg    <= '0;
        end else if (push && (wr_idx == SLOT)) begin
          instr_reg <= push_instr;
          pc_reg    <= push_pc;
        end else if (pop) begin
          instr_reg <= shift_instr;
          pc_reg    <= shift_pc;
        end
      end
    end
  endgenerate

  assign count      = count_reg;
  assign head_instr = g_slot[0].instr_reg;
  assign head_pc    = g_slot[0].pc_reg;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/issue stage: PC, request/kill tracking for a 1-cycle
// instruction memory, 2-entry queue toward decode, and a RUN/HALT FSM.
// Optional feature macro: IFU_ILLEGAL_TRAP_EN (halt and flag on a reserved
// opcode entering the queue; a redirect clears it and resumes fetch).
module instr_fetch_unit
  import isa_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               ifu_valid,
  input  logic               ifu_ready,
  output logic [INSTR_W-1:0] ifu_instr,
  output logic [3:0]         ifu_opcode,
  output logic [ADDR_W-1:0]  ifu_pc,
  output logic               ifu_illegal
);

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] out_pc_reg;
  logic              out_reg;
  ifu_state_t        state_reg;
  logic              illegal_reg;

  logic [1:0] count;
  logic [2:0] pending;
  logic       pop;
  logic       push;
  logic       req;

  assign ifu_valid = (count != 2'd0);
  assign pop       = ifu_valid && ifu_ready;
  // The response of the previous request is captured unless a redirect kills it.
  assign push      = out_reg && !redirect_valid;
  // Entries the queue will have to hold once everything in flight lands.
  assign pending   = {1'b0, count} + {2'b0, out_reg} - {2'b0, pop};
  // rst_n gating keeps the request low while reset is held.
  assign req       = rst_n && (state_reg == ST_RUN) && !redirect_valid && (pending < 3'd2);

  assign imem_req   = req;
  assign imem_addr  = pc_reg;
  assign ifu_opcode = ifu_instr[INSTR_W-1 -: 4];
  assign ifu_illegal = illegal_reg;

  // PC and in-flight request tracking; redirect drops the outstanding response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg     <= RESET_PC;
      out_reg    <= 1'b0;
      out_pc_reg <= '0;
    end else if (redirect_valid) begin
      pc_reg  <= redirect_pc;
      out_reg <= 1'b0;
    end else begin
      out_reg <= req;
      if (req) begin
        out_pc_reg <= pc_reg;
        pc_reg     <= pc_reg + 1'b1;
      end
    end
  end

`ifdef IFU_ILLEGAL_TRAP_EN
  // Fetch FSM: a reserved opcode being queued halts fetch; redirect resumes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_RUN;
      illegal_reg <= 1'b0;
    end else if (redirect_valid) begin
      state_reg   <= ST_RUN;
      illegal_reg <= 1'b0;
    end else if (push && !is_legal_op(imem_rdata[INSTR_W-1 -: 4])) begin
      state_reg   <= ST_HALT;
      illegal_reg <= 1'b1;
    end
  end
`else
  // Fetch FSM without opcode checking: always running, never flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_RUN;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= ST_RUN;
      illegal_reg <= 1'b0;
    end
  end
`endif

  ifu_queue #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_instr(imem_rdata),
    .push_pc   (out_pc_reg),
    .count     (count),
    .head_instr(ifu_instr),
    .head_pc   (ifu_pc)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a queue-based model of the fetch rules is
// compared against the DUT every cycle, with literal expectations per scenario.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        ifu_valid;
  logic        ifu_ready = 1'b0;
  logic [15:0] ifu_instr;
  logic [3:0]  ifu_opcode;
  logic [7:0]  ifu_pc;
  logic        ifu_illegal;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ifu_valid(ifu_valid), .ifu_ready(ifu_ready), .ifu_instr(ifu_instr),
    .ifu_opcode(ifu_opcode), .ifu_pc(ifu_pc), .ifu_illegal(ifu_illegal)
  );

  int pass_cnt = 0;
  int check_cnt = 0;

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] instr;
  } entry_t;

  entry_t     mq[$];
  bit         m_out, m_halt, m_illegal;
  logic [7:0] m_out_pc, m_pc;
  bit         mem_prev_req;
  logic [7:0] mem_prev_addr;
  bit         trap_mode = 1'b0;
  int         cyc;
  int         first_valid_cyc;
  logic [7:0] pop_log[$];
  int         pop_cyc[$];
  logic [7:0] req_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Memory image: opcode cycles through the legal ones; PC 2 is reserved in trap_mode.
  function automatic logic [15:0] mem_word(input logic [7:0] a);
    logic [3:0] op;
    op = (trap_mode && a == 8'd2) ? 4'hA : {2'b00, a[1:0]};
    return {op, 4'h0, a};
  endfunction

  function automatic logic [8:0] at_pop(input int i);
    return (i >= 0 && i < pop_log.size()) ? {1'b0, pop_log[i]} : 9'h1FF;
  endfunction

  function automatic logic [8:0] at_req(input int i);
    return (i >= 0 && i < req_log.size()) ? {1'b0, req_log[i]} : 9'h1FF;
  endfunction

  function automatic int at_popcyc(input int i);
    return (i >= 0 && i < pop_cyc.size()) ? pop_cyc[i] : -1;
  endfunction

  task automatic model_reset();
    mq.delete(); pop_log.delete(); pop_cyc.delete(); req_log.delete();
    m_out = 0; m_halt = 0; m_illegal = 0; m_pc = 8'h00; m_out_pc = 8'h00;
    mem_prev_req = 0; mem_prev_addr = 8'h00; cyc = 0; first_valid_cyc = -1;
  endtask

  // Reset held low, then released just before the cycle numbered 0.
  task automatic do_reset();
    rst_n = 1'b0; ifu_ready = 1'b0; redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    #2 rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, check outputs vs model, advance the model.
  task automatic step(input bit rdy, input bit redir, input logic [7:0] rpc);
    bit exp_valid, pop, exp_req;
    entry_t e;
    @(negedge clk);
    ifu_ready = rdy; redirect_valid = redir; redirect_pc = rpc;
    imem_rdata = mem_prev_req ? mem_word(mem_prev_addr) : 16'($urandom);
    #1;
    exp_valid = (mq.size() != 0);
    pop = exp_valid && rdy;
    exp_req = !m_halt && !redir && ((mq.size() + int'(m_out) - int'(pop)) < 2);
    check("ifu_valid", ifu_valid, exp_valid);
    if (exp_valid) begin
      check("ifu_pc", ifu_pc, mq[0].pc);
      check("ifu_instr", ifu_instr, mq[0].instr);
      check("ifu_opcode", ifu_opcode, mq[0].instr[15:12]);
    end
    check("imem_req", imem_req, exp_req);
    if (exp_req) check("imem_addr", imem_addr, m_pc);
    check("ifu_illegal", ifu_illegal, m_illegal);
    if (exp_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (pop) begin
      e = mq.pop_front();
      pop_log.push_back(e.pc); pop_cyc.push_back(cyc);
      $display("cycle %0d: issue pc=%02h instr=%04h", cyc, e.pc, e.instr);
    end
    if (exp_req) req_log.push_back(m_pc);
    if (redir) begin
      mq.delete(); m_out = 0; m_pc = rpc; m_halt = 0; m_illegal = 0;
    end else begin
      if (m_out) begin
        mq.push_back(entry_t'({m_out_pc, imem_rdata}));
`ifdef IFU_ILLEGAL_TRAP_EN
        if (imem_rdata[15:12] > 4'd3) begin m_halt = 1; m_illegal = 1; end
`endif
      end
      if (exp_req) begin m_out_pc = m_pc; m_pc = m_pc + 8'd1; end
      m_out = exp_req;
    end
    mem_prev_req = imem_req; mem_prev_addr = imem_addr;
    cyc++;
  endtask

  initial begin
    int base;
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst imem_req", imem_req, 0);
    check("rst imem_addr", imem_addr, 0);
    check("rst ifu_valid", ifu_valid, 0);
    check("rst ifu_instr", ifu_instr, 0);
    check("rst ifu_opcode", ifu_opcode, 0);
    check("rst ifu_pc", ifu_pc, 0);
    check("rst ifu_illegal", ifu_illegal, 0);

    // Streaming with ready held high, then redirect and back-to-back redirect
    do_reset();
    repeat (12) step(1, 0, 8'h00);
    check("stream req0", at_req(0), 9'h000);
    check("stream req3", at_req(3), 9'h003);
    check("stream first valid", first_valid_cyc, 2);
    check("stream pop count", pop_log.size(), 10);
    check("stream pop2", at_pop(2), 9'h002);
    check("stream pop9", at_pop(9), 9'h009);
    step(0, 1, 8'h40);
    base = pop_log.size();
    repeat (6) step(1, 0, 8'h00);
    check("redir first pc", at_pop(base), 9'h040);
    check("redir latency", at_popcyc(base), 12 + 3);
    check("redir second pc", at_pop(base + 1), 9'h041);
    step(1, 1, 8'h20);
    step(1, 1, 8'h30);
    base = pop_log.size();
    repeat (5) step(1, 0, 8'h00);
    check("b2b last wins", at_pop(base), 9'h030);
    check("b2b latency", at_popcyc(base), 20 + 3);

    // Backpressure for 5 cycles after the first valid
    do_reset();
    repeat (2) step(1, 0, 8'h00);
    repeat (5) step(0, 0, 8'h00);
    check("bp req count", req_log.size(), 2);
    check("bp no pops", pop_log.size(), 0);
    repeat (8) step(1, 0, 8'h00);
    check("bp pop0", at_pop(0), 9'h000);
    check("bp pop1", at_pop(1), 9'h001);
    check("bp pop2", at_pop(2), 9'h002);
    check("bp pop0 cycle", at_popcyc(0), 7);
    check("bp pop2 cycle", at_popcyc(2), 9);
    // Asynchronous reset mid-operation
    rst_n = 1'b0;
    #1;
    check("async rst valid", ifu_valid, 0);
    check("async rst req", imem_req, 0);
    check("async rst pc", ifu_pc, 0);

    // Redirect while PC 7 pops, target near the top of the address space
    do_reset();
    repeat (9) step(1, 0, 8'h00);
    step(1, 1, 8'hFE);
    base = pop_log.size();
    check("simul pop7", at_pop(base - 1), 9'h007);
    base = req_log.size();
    repeat (7) step(1, 0, 8'h00);
    check("wrap req0", at_req(base), 9'h0FE);
    check("wrap req1", at_req(base + 1), 9'h0FF);
    check("wrap req2", at_req(base + 2), 9'h000);
    check("wrap req3", at_req(base + 3), 9'h001);
    check("wrap first pop", at_pop(8), 9'h0FE);
    check("wrap pop after ff", at_pop(10), 9'h000);

    // Reserved opcode at PC 2
    trap_mode = 1'b1;
    do_reset();
    repeat (12) step(1, 0, 8'h00);
`ifdef IFU_ILLEGAL_TRAP_EN
    check("trap flag", ifu_illegal, 1);
    check("trap req count", req_log.size(), 4);
    check("trap pop count", pop_log.size(), 4);
    check("trap pop2", at_pop(2), 9'h002);
`else
    check("notrap flag", ifu_illegal, 0);
    check("notrap req count", req_log.size(), 12);
    check("notrap pop count", pop_log.size(), 10);
    check("notrap pop2", at_pop(2), 9'h002);
`endif
    step(1, 1, 8'h10);
    base = pop_log.size();
    repeat (5) step(1, 0, 8'h00);
    check("trap resume flag", ifu_illegal, 0);
    check("trap resume pc", at_pop(base), 9'h010);
    trap_mode = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
